imem_responder: RTL
===================

# imem_responder

Instruction-memory responder for the wizardCore fetch path. Answers word fetches issued by the fetch stage (address out, instruction back) after a fixed, parameterised latency, with a valid strobe and a busy indicator. Also owns the program-load port that fills the storage array from a host/testbench word stream before the core is released. Sits between the IF stage's instruction-address output and its instruction input.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words stored; power of two, 16..65536
- READ_LATENCY, 1, cycles from accepted request to o_valid; legal 1..4
- i_clk  in  1  clock
- i_reset_n  in  1  synchronous, active-low reset
- i_req  in  1  fetch request; accepted only when o_busy=0
- i_mem_instrAddr  in  32  byte address of fetch, sampled on accept
- o_mem_instr  out  32  fetched instruction; held between responses
- o_valid  out  1  one-cycle pulse: o_mem_instr/o_fault valid
- o_fault  out  1  response is a fault (misaligned, out of range, parity)
- o_busy  out  1  high in LOAD and WAIT states
- i_ld_start  in  1  begin program load at word 0
- i_ld_valid  in  1  load word present
- i_ld_data  in  32  load word
- i_ld_last  in  1  qualifies final load word
- o_ld_ready  out  1  high in LOAD state
- o_ld_count  out  $clog2(DEPTH_WORDS)+1  words written in current/last load

## Operation
- States: IDLE, LOAD, WAIT, RESP.
- IDLE: i_ld_start -> LOAD (count cleared). Else i_req -> WAIT (READ_LATENCY>1) or RESP (READ_LATENCY=1). i_ld_start and i_req together: load wins, request dropped.
- LOAD: each cycle with i_ld_valid, write i_ld_data at word o_ld_count, count +1. Exit to IDLE after word with i_ld_last, or after word DEPTH_WORDS-1 (no wrap; later words never written). i_req ignored.
- WAIT: internal counter runs READ_LATENCY-1 cycles, then RESP.
- RESP: o_valid=1 one cycle. o_busy=0, so a new i_req is accepted here (back-to-back, same transition rules as IDLE); otherwise -> IDLE. i_ld_start ignored in RESP.
- Fault check on accepted address: addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS -> o_fault=1, o_mem_instr=32'h0000_0013 (NOP), array not read.
- Good response: o_mem_instr = word addr[31:2], o_fault=0.
- Storage contents not cleared by reset.

## Timing
- Reset values: o_mem_instr=32'h0000_0013, o_valid=0, o_fault=0, o_busy=0, o_ld_ready=0, o_ld_count=0, state IDLE.
- Request accepted at edge N -> o_valid high cycle N+READ_LATENCY; max throughput one response per READ_LATENCY cycles.
- o_mem_instr and o_fault registered; change only on the o_valid cycle.
- Load write visible to a fetch accepted the cycle after LOAD exits.
- Reset mid-load: load aborted, words already written retained, o_ld_count=0.
- Reset mid-read: response discarded, no o_valid.

## Configuration
- IMEM_PARITY_EN defined: array 33 bits wide; even parity bit generated on each load write; checked on read; mismatch -> o_fault=1, o_mem_instr=NOP.
- Undefined: array 32 bits; o_fault only for misalignment/range.

## Structure
- Package imem_pkg: state enum imem_state_t, IMEM_NOP=32'h0000_0013, parity function.
- One sub-module imem_array: single write port, single registered read port, storage named mem_q, width 32 or 33 per IMEM_PARITY_EN.

## Test plan
- Load 4 words (0x00500093, 0x00A00113, 0x002081B3, 0x0000006F, last on 4th) -> o_ld_count=4; fetch 0x8 at latency 1 -> o_valid next cycle, o_mem_instr=0x002081B3, o_fault=0.
- READ_LATENCY=3, i_req at 0x4 -> o_busy high 2 cycles, o_valid exactly 3 cycles after accept, data 0x00A00113; back-to-back req in RESP cycle accepted.
- Fetch 0x6 and 0x1000 (DEPTH_WORDS=1024) -> o_fault=1, o_mem_instr=0x00000013.
- i_ld_start and i_req same cycle -> LOAD entered, no o_valid; load of DEPTH_WORDS+2 words -> o_ld_ready drops after word DEPTH_WORDS-1, count=DEPTH_WORDS.
- Reset asserted mid-load after 2 words and mid-WAIT -> outputs at reset values, no o_valid, words 0-1 readable afterward.
- IMEM_PARITY_EN: corrupt mem_q[2] bit 32 hierarchically, fetch 0x8 -> o_fault=1, NOP; without macro same fetch returns stored data.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared state encoding, NOP constant and parity helper for the instruction memory.
package imem_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} imem_state_t;
  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;
  function automatic logic parity(input logic [31:0] w);
    return ^w;
  endfunction
endpackage

// File: rtl/imem_array.sv
// imem_array: word storage with one write port and one registered read port.
module imem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int W           = 32,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] mem_q [DEPTH_WORDS];
  logic [W-1:0] rdata_q;
  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
    if (i_re) rdata_q <= mem_q[i_raddr];
  end
  assign o_rdata = rdata_q;
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction fetch responder with a program-load port.
// Define IMEM_PARITY_EN to store an even-parity bit per word and fault on mismatch.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_req,
  input  logic [31:0]                  i_mem_instrAddr,
  output logic [31:0]                  o_mem_instr,
  output logic                         o_valid,
  output logic                         o_fault,
  output logic                         o_busy,
  input  logic                         i_ld_start,
  input  logic                         i_ld_valid,
  input  logic [31:0]                  i_ld_data,
  input  logic                         i_ld_last,
  output logic                         o_ld_ready,
  output logic [$clog2(DEPTH_WORDS):0] o_ld_count
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW:0] LAST_WORD = (AW+1)'(DEPTH_WORDS - 1);
  imem_state_t state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic [1:0] wait_q, wait_d;
  logic [AW-1:0] addr_q, raddr;
  logic bad_q, chk_q, flt_q, valid_q, busy_q, ready_q;
  logic accept, acc_bad, go_resp, resp_bad, we, par_err;
`ifdef IMEM_PARITY_EN
  localparam int W = 33;
  logic [W-1:0] wdata, rdata;
  assign wdata   = {parity(i_ld_data), i_ld_data};
  assign par_err = chk_q && ^rdata;
`else
  localparam int W = 32;
  logic [W-1:0] wdata, rdata;
  assign wdata   = i_ld_data;
  assign par_err = 1'b0;
`endif
  assign accept   = (state_q == RESP || (state_q == IDLE && !i_ld_start)) && i_req;
  assign acc_bad  = |i_mem_instrAddr[1:0] || |i_mem_instrAddr[31:AW+2];
  // The array is read on the edge entering RESP, so the data lands exactly on the o_valid cycle.
  assign go_resp  = state_q == WAIT ? wait_q == 2'd0 : accept && READ_LATENCY == 1;
  assign resp_bad = state_q == WAIT ? bad_q : acc_bad;
  assign raddr    = state_q == WAIT ? addr_q : i_mem_instrAddr[AW+1:2];
  assign we       = i_reset_n && state_q == LOAD && i_ld_valid;
  always_comb begin
    count_d = state_q == IDLE && i_ld_start ? '0 : we ? count_q + (AW+1)'(1) : count_q;
    wait_d  = state_q == WAIT ? wait_q - 2'd1 : 2'(READ_LATENCY - 2);
    case (state_q)
      LOAD:    state_d = we && (i_ld_last || count_q == LAST_WORD) ? IDLE : LOAD;
      WAIT:    state_d = wait_q == 2'd0 ? RESP : WAIT;
      default: state_d = state_q == IDLE && i_ld_start ? LOAD : accept ? (READ_LATENCY == 1 ? RESP : WAIT) : IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      wait_q  <= '0;
      addr_q  <= '0;
      bad_q   <= 1'b0;
      chk_q   <= 1'b0;
      flt_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      valid_q <= state_d == RESP;
      busy_q  <= state_d == LOAD || state_d == WAIT;
      ready_q <= state_d == LOAD;
      if (accept) begin
        addr_q <= i_mem_instrAddr[AW+1:2];
        bad_q  <= acc_bad;
      end
      if (go_resp) begin
        chk_q <= !resp_bad;
        flt_q <= resp_bad;
      end
    end
  end
  imem_array #(.DEPTH_WORDS(DEPTH_WORDS), .W(W)) u_array (
    .i_clk  (i_clk),
    .i_we   (we),
    .i_waddr(count_q[AW-1:0]),
    .i_wdata(wdata),
    .i_re   (go_resp && !resp_bad),
    .i_raddr(raddr),
    .o_rdata(rdata)
  );
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;
  assign o_ld_ready  = ready_q;
  assign o_ld_count  = count_q;
  assign o_fault     = flt_q || par_err;
  assign o_mem_instr = chk_q && !par_err ? rdata[31:0] : IMEM_NOP;
endmodule
